// File: rtl/regfile_pkg.sv
// Shared constants and derived-width helpers for the register file and its scoreboard.
package regfile_pkg;

   localparam int REG_ZERO = 0;

   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write bits, registered pending count and sticky double-issue error.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NUM_REGS = 32,
   localparam int ADDR_W   = addr_w(NUM_REGS),
   localparam int CNT_W    = cnt_w(NUM_REGS)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_reg_i,
   input  logic              iss_en_i,
   input  logic [ADDR_W-1:0] iss_reg_i,
   input  logic [ADDR_W-1:0] look_a_i,
   input  logic [ADDR_W-1:0] look_b_i,
   output logic              pend_a_o,
   output logic              pend_b_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              err_o
);

   logic [NUM_REGS-1:0] pend_q, pend_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                err_q, err_d;
   logic                wr_hit, iss_hit;

   always_comb begin
      wr_hit  = wr_en_i  && (wr_reg_i  != ADDR_W'(REG_ZERO));
      iss_hit = iss_en_i && (iss_reg_i != ADDR_W'(REG_ZERO));

      // Clear before set so a same-cycle issue to the written register wins.
      pend_d = pend_q;
      if (wr_hit)  pend_d[wr_reg_i]  = 1'b0;
      if (iss_hit) pend_d[iss_reg_i] = 1'b1;

      err_d = err_q | (iss_hit && pend_q[iss_reg_i] && !(wr_hit && (wr_reg_i == iss_reg_i)));

      count_d = '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         count_d = count_d + CNT_W'(pend_d[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pend_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign pend_a_o = pend_q[look_a_i];
   assign pend_b_o = pend_q[look_b_i];
   assign count_o  = count_q;
   assign err_o    = err_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// NUM_REGS x DATA_W register file, two async reads, one sync write, r0 hardwired to zero, with scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int DATA_W   = 32,
   parameter  int NUM_REGS = 32,
   localparam int ADDR_W   = addr_w(NUM_REGS),
   localparam int CNT_W    = cnt_w(NUM_REGS)
) (
   input  logic              clock,
   input  logic              ctrl_reset_n,
   input  logic              ctrl_writeEnable,
   input  logic [ADDR_W-1:0] ctrl_writeReg,
   input  logic [DATA_W-1:0] data_writeReg,
   input  logic              ctrl_issueEnable,
   input  logic [ADDR_W-1:0] ctrl_issueReg,
   input  logic [ADDR_W-1:0] ctrl_readRegA,
   input  logic [ADDR_W-1:0] ctrl_readRegB,
   output logic [DATA_W-1:0] data_readRegA,
   output logic [DATA_W-1:0] data_readRegB,
   output logic              busy_readRegA,
   output logic              busy_readRegB,
   output logic [CNT_W-1:0]  pending_count,
   output logic              err_doubleIssue
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic              wr_hit;
   logic              pend_a, pend_b;

   assign wr_hit = ctrl_writeEnable && (ctrl_writeReg != ADDR_W'(REG_ZERO));

   always_ff @(posedge clock) begin
      if (!ctrl_reset_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_hit) begin
         regs_q[ctrl_writeReg] <= data_writeReg;
      end
   end

   reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
      .clock     (clock),
      .reset_n   (ctrl_reset_n),
      .wr_en_i   (ctrl_writeEnable),
      .wr_reg_i  (ctrl_writeReg),
      .iss_en_i  (ctrl_issueEnable),
      .iss_reg_i (ctrl_issueReg),
      .look_a_i  (ctrl_readRegA),
      .look_b_i  (ctrl_readRegB),
      .pend_a_o  (pend_a),
      .pend_b_o  (pend_b),
      .count_o   (pending_count),
      .err_o     (err_doubleIssue)
   );

   // Read muxes replace the old tristate buses; r0 override is applied last.
   always_comb begin
      data_readRegA = regs_q[ctrl_readRegA];
      busy_readRegA = pend_a;
      data_readRegB = regs_q[ctrl_readRegB];
      busy_readRegB = pend_b;
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (ctrl_writeReg == ctrl_readRegA)) begin
         data_readRegA = data_writeReg;
         busy_readRegA = ctrl_issueEnable && (ctrl_issueReg == ctrl_readRegA);
      end
      if (wr_hit && (ctrl_writeReg == ctrl_readRegB)) begin
         data_readRegB = data_writeReg;
         busy_readRegB = ctrl_issueEnable && (ctrl_issueReg == ctrl_readRegB);
      end
`endif
      if (ctrl_readRegA == ADDR_W'(REG_ZERO)) begin
         data_readRegA = '0;
         busy_readRegA = 1'b0;
      end
      if (ctrl_readRegB == ADDR_W'(REG_ZERO)) begin
         data_readRegB = '0;
         busy_readRegB = 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized self-checking bench for regfile_scoreboard against an array-based reference model.
module tb_regfile_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
);
   localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int CNT_W  = $clog2(NUM_REGS + 1);
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              rst_n, we, ie;
   logic [ADDR_W-1:0] wr, is, ra, rb;
   logic [DATA_W-1:0] wd;
   logic [DATA_W-1:0] da, db;
   logic              ba, bb;
   logic [CNT_W-1:0]  cnt;
   logic              err;

   always #5 clock = ~clock;

   regfile_scoreboard #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
      .clock            (clock),
      .ctrl_reset_n     (rst_n),
      .ctrl_writeEnable (we),
      .ctrl_writeReg    (wr),
      .data_writeReg    (wd),
      .ctrl_issueEnable (ie),
      .ctrl_issueReg    (is),
      .ctrl_readRegA    (ra),
      .ctrl_readRegB    (rb),
      .data_readRegA    (da),
      .data_readRegB    (db),
      .busy_readRegA    (ba),
      .busy_readRegB    (bb),
      .pending_count    (cnt),
      .err_doubleIssue  (err)
   );

   // Reference model state
   logic [DATA_W-1:0] mregs [NUM_REGS];
   bit                mpend [NUM_REGS];
   int                mcount;
   bit                merr;
   int                n_cmp = 0;
   int                n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output logic b);
      int ai;
      ai = int'(a);
      if (ai == 0) begin
         d = '0;
         b = 1'b0;
      end else if (BYP && we && (wr == a)) begin
         d = wd;
         b = ie && (is == a);
      end else begin
         d = mregs[ai];
         b = mpend[ai];
      end
   endtask

   task automatic compare_all();
      logic [DATA_W-1:0] ed;
      logic              eb;
      exp_read(ra, ed, eb);
      chk("dataA", 64'(da), 64'(ed));
      chk("busyA", 64'(ba), 64'(eb));
      exp_read(rb, ed, eb);
      chk("dataB", 64'(db), 64'(ed));
      chk("busyB", 64'(bb), 64'(eb));
      chk("count", 64'(cnt), 64'(mcount));
      chk("err",   64'(err), 64'(merr));
   endtask

   task automatic model_edge();
      int  wi, ii;
      bit  wh, ih;
      wi = int'(wr);
      ii = int'(is);
      wh = we && (wi != 0);
      ih = ie && (ii != 0);
      if (!rst_n) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            mregs[k] = '0;
            mpend[k] = 1'b0;
         end
         mcount = 0;
         merr   = 1'b0;
      end else begin
         if (ih && mpend[ii] && !(wh && wi == ii)) merr = 1'b1;
         if (wh) begin
            mregs[wi] = wd;
            if (mpend[wi]) begin
               mpend[wi] = 1'b0;
               mcount--;
            end
         end
         if (ih && !mpend[ii]) begin
            mpend[ii] = 1'b1;
            mcount++;
         end
      end
   endtask

   task automatic drive(input bit r, input bit w_en, input int w_a, input logic [DATA_W-1:0] w_d,
                        input bit i_en, input int i_a, input int a_a, input int b_a);
      rst_n = r;
      we    = w_en;
      wr    = ADDR_W'(w_a);
      wd    = w_d;
      ie    = i_en;
      is    = ADDR_W'(i_a);
      ra    = ADDR_W'(a_a);
      rb    = ADDR_W'(b_a);
   endtask

   task automatic step();
      @(negedge clock);
      compare_all();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   logic [DATA_W-1:0] c_beef, c_a5;

   initial begin
      c_beef = DATA_W'(32'hDEADBEEF);
      c_a5   = DATA_W'(32'hA5A5A5A5);
      for (int k = 0; k < NUM_REGS; k++) begin
         mregs[k] = '0;
         mpend[k] = 1'b0;
      end
      mcount = 0;
      merr   = 1'b0;

      // Reset; per-cycle compares wait until the model has seen reset.
      drive(1'b0, 1'b0, 0, '0, 1'b0, 0, 0, 0);
      @(posedge clock); model_edge(); #1;
      step();

      // 1: all addresses read zero after reset
      for (int a = 0; a < NUM_REGS; a++) begin
         drive(1'b1, 1'b0, 0, '0, 1'b0, 0, a, NUM_REGS - 1 - a);
         step();
      end
      chk("t1_count", 64'(cnt), 64'd0);
      chk("t1_err",   64'(err), 64'd0);

      // 2: write r5, write to r0 ignored
      drive(1'b1, 1'b1, 5, c_beef, 1'b0, 0, 5, 0);
      step();
      chk("t2_r5", 64'(da), 64'(c_beef));
      drive(1'b1, 1'b1, 0, DATA_W'(32'h1234), 1'b0, 0, 0, 0);
      step();
      chk("t2_r0", 64'(da), 64'd0);

      // 3: issue r7 then r9, then write r7
      drive(1'b1, 1'b0, 0, '0, 1'b1, 7, 7, 0);
      step();
      chk("t3_count1", 64'(cnt), 64'd1);
      drive(1'b1, 1'b0, 0, '0, 1'b1, 9, 7, 0);
      step();
      chk("t3_count2", 64'(cnt), 64'd2);
      chk("t3_busy7",  64'(ba),  64'd1);
      drive(1'b1, 1'b1, 7, DATA_W'(32'h77), 1'b0, 0, 7, 0);
      step();
      chk("t3_busy7_clr", 64'(ba),  64'd0);
      chk("t3_count_dec", 64'(cnt), 64'd1);

      // 4: same-cycle write+issue keeps pending, then a true double issue
      drive(1'b1, 1'b0, 0, '0, 1'b1, 3, 3, 0);
      step();
      chk("t4_count_a", 64'(cnt), 64'd2);
      drive(1'b1, 1'b1, 3, DATA_W'(32'h55), 1'b1, 3, 3, 0);
      step();
      chk("t4_count_b", 64'(cnt), 64'd2);
      chk("t4_busy3",   64'(ba),  64'd1);
      chk("t4_err0",    64'(err), 64'd0);
      drive(1'b1, 1'b0, 0, '0, 1'b1, 3, 3, 0);
      step();
      chk("t4_err1", 64'(err), 64'd1);
      drive(1'b1, 1'b0, 0, '0, 1'b0, 0, 3, 0);
      step();
      chk("t4_err_sticky", 64'(err), 64'd1);

      // 5: write r4 while both ports read it
      drive(1'b1, 1'b1, 4, c_a5, 1'b0, 0, 4, 4);
      #1;
      chk("t5_sameA", 64'(da), BYP ? 64'(c_a5) : 64'd0);
      chk("t5_sameB", 64'(db), BYP ? 64'(c_a5) : 64'd0);
      step();
      chk("t5_nextA", 64'(da), 64'(c_a5));
      chk("t5_nextB", 64'(db), 64'(c_a5));

      // 6: reset overrides a write to a pending register
      drive(1'b1, 1'b0, 0, '0, 1'b1, 6, 6, 0);
      step();
      drive(1'b0, 1'b1, 6, DATA_W'(32'h66), 1'b1, 6, 6, 6);
      step();
      drive(1'b1, 1'b0, 0, '0, 1'b0, 0, 6, 6);
      #1;
      chk("t6_data",  64'(da),  64'd0);
      chk("t6_busy",  64'(ba),  64'd0);
      chk("t6_count", 64'(cnt), 64'd0);
      chk("t6_err",   64'(err), 64'd0);

      // Randomized traffic with occasional reset
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1,
               int'($urandom_range(0, NUM_REGS - 1)), DATA_W'($urandom),
               $urandom_range(0, 2) != 0, int'($urandom_range(0, NUM_REGS - 1)),
               int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(0, NUM_REGS - 1)));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
